// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
package muldiv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ACC_W = 2 * XLEN;
  localparam int unsigned ITER  = 32;
  localparam int unsigned CNT_W = 6;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_RUN,
    ST_FIX,
    ST_DONE,
    ST_ERR
  } state_e;

  // Two's-complement negate when n is set, otherwise pass through.
  function automatic logic [XLEN-1:0] neg_if(input logic n, input logic [XLEN-1:0] v);
    return n ? XLEN'(-v) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add for MULT, restoring shift-subtract for DIV.
// Accumulator layout: MULT {partial_hi, multiplier}, DIV {remainder, dividend/quotient}.
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic             op_i,
  input  logic [ACC_W-1:0] acc_i,
  input  logic [XLEN-1:0]  opnd_i,
  output logic [ACC_W-1:0] acc_o
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;

  always_comb begin
    sum     = {1'b0, acc_i[ACC_W-1:XLEN]} + {1'b0, (acc_i[0] ? opnd_i : XLEN'(0))};
    shifted = {acc_i[ACC_W-1:XLEN], acc_i[XLEN-1]};
    // Remainder stays below the divisor, so the difference always fits XLEN bits.
    diff    = shifted[XLEN-1:0] - opnd_i;
    if (op_i == OP_MULT) begin
      acc_o = {sum, acc_i[XLEN-1:1]};
    end else if (shifted >= {1'b0, opnd_i}) begin
      acc_o = {diff, acc_i[XLEN-2:0], 1'b1};
    end else begin
      acc_o = {shifted[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/DIV sequencer driving HI/LO load strobes.
// Define MULDIV_SIGNED_EN for two's-complement operands; default build is unsigned.
module muldiv_sequencer
  import muldiv_pkg::*;
(
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic            start_i,
  input  logic            op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            abort_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            div0_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o,
  output logic            hi_write_o,
  output logic            lo_write_o
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              div0_q, div0_d;
  logic              wr_q, wr_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;

  logic [ACC_W-1:0]  step_acc;
  logic              sign_a, sign_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [ACC_W-1:0]  prod;

  muldiv_step u_step (
    .op_i   (op_q),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (step_acc)
  );

  // Operand signs and magnitudes from the latched inputs.
  always_comb begin
`ifdef MULDIV_SIGNED_EN
    sign_a = a_q[XLEN-1];
    sign_b = b_q[XLEN-1];
`else
    sign_a = 1'b0;
    sign_b = 1'b0;
`endif
    mag_a = neg_if(sign_a, a_q);
    mag_b = neg_if(sign_b, b_q);
    prod  = neg_res_q ? ACC_W'(-acc_q) : acc_q;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    div0_d    = 1'b0;
    wr_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i && !abort_i) begin
          op_d = op_i;
          a_d  = a_i;
          b_d  = b_i;
          if (op_i == OP_DIV && b_i == XLEN'(0)) begin
            state_d = ST_ERR;
            div0_d  = 1'b1;
          end else begin
            state_d = ST_PREP;
          end
        end
      end
      ST_PREP: begin
        acc_d     = (op_q == OP_MULT) ? {XLEN'(0), mag_b} : {XLEN'(0), mag_a};
        opnd_d    = (op_q == OP_MULT) ? mag_a : mag_b;
        neg_res_d = sign_a ^ sign_b;
        neg_rem_d = sign_a;
        cnt_d     = CNT_W'(0);
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        acc_d = step_acc;
        if (cnt_q == CNT_W'(ITER - 1)) begin
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FIX: begin
        if (op_q == OP_MULT) begin
          hi_d = prod[ACC_W-1:XLEN];
          lo_d = prod[XLEN-1:0];
        end else begin
          hi_d = neg_if(neg_rem_q, acc_q[ACC_W-1:XLEN]);
          lo_d = neg_if(neg_res_q, acc_q[XLEN-1:0]);
        end
        done_d  = 1'b1;
        wr_d    = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Cancel wins over any result or exception about to be presented.
    if (abort_i && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
      div0_d  = 1'b0;
      wr_d    = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= OP_MULT;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      div0_q    <= 1'b0;
      wr_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      div0_q    <= div0_d;
      wr_q      <= wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign div0_o     = div0_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign hi_write_o = wr_q;
  assign lo_write_o = wr_q;

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 clk  input  1  system clock; all state changes on its rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; forces the IDLE state immediately.
REQ-003 start  input  1  one-cycle request from Control; sampled only in IDLE.
REQ-004 op  input  1  operation select; 0 = MULT, 1 = DIV; sampled with start.
REQ-005 a  input  32  multiplicand or dividend (rs); sampled with start.
REQ-006 b  input  32  multiplier or divisor (rt); sampled with start.
REQ-007 abort  input  1  synchronous cancel of the operation in flight.
REQ-008 busy  output  1  high in every non-IDLE state.
REQ-009 done  output  1  one-cycle pulse when a valid result is presented.
REQ-010 div0  output  1  one-cycle pulse on DIV with b == 0.
REQ-011 hi  output  32  MULT: product[63:32]; DIV: remainder.
REQ-012 lo  output  32  MULT: product[31:0]; DIV: quotient.
REQ-013 hiWrite, loWrite  output  1 each  HI/LO register load strobes; asserted only together with done.

Function
REQ-014 States SHALL be IDLE, PREP, RUN, FIX, DONE and ERR.
REQ-015 IDLE + start + op=1 + b==0 SHALL go to ERR; otherwise IDLE + start SHALL go to PREP and latch op, a and b.
REQ-016 PREP SHALL, in one cycle, form operand magnitudes, record the result signs and clear a 6-bit counter.
REQ-017 RUN SHALL last exactly 32 cycles: one shift-add (MULT) or one restoring shift-subtract (DIV) step per cycle; the counter runs 0..31, and at 31 the block goes to FIX.
REQ-018 FIX SHALL apply sign correction in one cycle: product negated if the operand signs differ; quotient negated if the signs differ; remainder takes the dividend's sign.
REQ-019 DONE SHALL hold for one cycle with done = hiWrite = loWrite = 1, then return to IDLE.
REQ-020 Latency: with start in cycle 0, DONE SHALL occur in cycle 35 and IDLE in cycle 36.
REQ-021 ERR SHALL hold for one cycle with div0 = 1 and no HI/LO strobes, then return to IDLE.
REQ-022 start while busy SHALL be ignored, with no queuing.
REQ-023 abort in any non-IDLE state SHALL return to IDLE on the next edge with no strobes; abort has priority over start and over the DONE/ERR outputs of that cycle.
REQ-024 hi and lo SHALL hold their last result until the next DONE; they are undefined during RUN.
REQ-025 DIV of 0x80000000 by 0xFFFFFFFF (signed build) SHALL give lo = 0x80000000 and hi = 0 with no exception; the overflow is left to software.
REQ-026 All arithmetic SHALL be modulo 2^32 per result half; the internal accumulator is 64 bits (MULT) or 33 bits (DIV).

Reset
REQ-027 reset low SHALL force IDLE, counter = 0, busy = done = div0 = hiWrite = loWrite = 0 and hi = lo = 0.
REQ-028 Reset asserted mid-operation SHALL discard the operation; no strobe fires after reset is released.

Configuration
REQ-029 With MULDIV_SIGNED_EN defined, the operands SHALL be two's-complement and PREP/FIX SHALL apply the sign handling above.
REQ-030 Without MULDIV_SIGNED_EN, the operands SHALL be unsigned, PREP/FIX SHALL pass values unchanged, and the latency of REQ-020 is unchanged.

Structure
REQ-031 Shared package muldiv_pkg SHALL hold the state enumeration, the op encodings (OP_MULT = 0, OP_DIV = 1) and ITER = 32.
REQ-032 One combinational sub-module, muldiv_step, SHALL implement a single MULT/DIV iteration; the FSM, counter and sign logic stay in muldiv_sequencer.

Verification
REQ-033 MULT a=7, b=-3 (signed build), start in cycle 0 -> done in cycle 35, hi=0xFFFFFFFF, lo=0xFFFFFFEB, both strobes high for one cycle.
REQ-034 DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); unsigned build with a=100, b=7 -> lo=14, hi=2.
REQ-035 DIV a=5, b=0 -> div0 pulse in cycle 1, busy high in cycle 1 only, no strobes, hi/lo unchanged.
REQ-036 MULT started, abort in cycle 10 -> IDLE in cycle 11, no done; a new start in cycle 11 completes normally in cycle 46.
REQ-037 Second start in cycle 5 of an operation -> ignored; exactly one done, in cycle 35.
REQ-038 reset low in cycle 20 of a DIV -> outputs zero immediately; after release, no spurious done or strobe within 40 cycles.
